// File: rtl/pc_register.sv
// Architectural PC, Y86-64 status code and IDLE/RUN/HALT run controller for the sequential core.
// Retires one instruction per RUN cycle unless a fault or halt stops the machine.
module pc_register #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [63:0]          pc_updated,
  input  logic [3:0]           icode,
  input  logic                 instr_valid,
  input  logic                 imem_error,
  output logic [63:0]          pc,
  output logic [2:0]           stat,
  output logic                 running,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  state_t               r_state, r_state_next;
  logic [63:0]          r_pc, r_pc_next;
  logic [2:0]           r_stat, r_stat_next;
  logic [CNT_WIDTH-1:0] r_cycle_count, r_cycle_count_next;
  logic [CNT_WIDTH-1:0] r_instr_count, r_instr_count_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_stat        <= STAT_AOK;
      r_cycle_count <= '0;
      r_instr_count <= '0;
    end else begin
      r_state       <= r_state_next;
      r_pc          <= r_pc_next;
      r_stat        <= r_stat_next;
      r_cycle_count <= r_cycle_count_next;
      r_instr_count <= r_instr_count_next;
    end
  end

  always_comb begin
    r_state_next       = r_state;
    r_pc_next          = r_pc;
    r_stat_next        = r_stat;
    r_cycle_count_next = r_cycle_count;
    r_instr_count_next = r_instr_count;
    case (r_state)
      IDLE: begin
        if (start) r_state_next = RUN;
      end
      RUN: begin
        // The terminating cycle still counts; the faulting PC stays visible for debug.
        r_cycle_count_next = r_cycle_count + CNT_ONE;
        if (imem_error) begin
          r_stat_next  = STAT_ADR;
          r_state_next = HALT;
        end else if (!instr_valid) begin
          r_stat_next  = STAT_INS;
          r_state_next = HALT;
        end else if (icode == 4'h0) begin
          r_stat_next  = STAT_HLT;
          r_state_next = HALT;
        end else begin
          r_pc_next          = pc_updated;
          r_instr_count_next = r_instr_count + CNT_ONE;
        end
      end
      HALT: begin
      end
      default: begin
        r_state_next = HALT;
        r_stat_next  = STAT_INS;
      end
    endcase
  end

  assign pc          = r_pc;
  assign stat        = r_stat;
  assign running     = (r_state == RUN);
  assign halted      = (r_state == HALT);
  assign cycle_count = r_cycle_count;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_pc_register.sv
// Directed bench for pc_register: the driver queues the expected architectural state after each edge,
// a negedge monitor pops and compares it, so stimulus and checking stay decoupled.
module tb_pc_register;

  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [63:0]   pc_updated;
  logic [3:0]    icode;
  logic          instr_valid;
  logic          imem_error;
  logic [63:0]   pc;
  logic [2:0]    stat;
  logic          running;
  logic          halted;
  logic [CW-1:0] cycle_count;
  logic [CW-1:0] instr_count;

  pc_register #(.RESET_PC(64'h0), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pc_updated  (pc_updated),
    .icode       (icode),
    .instr_valid (instr_valid),
    .imem_error  (imem_error),
    .pc          (pc),
    .stat        (stat),
    .running     (running),
    .halted      (halted),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );

  typedef struct {
    int            cyc;
    logic [63:0]   pc;
    logic [2:0]    stat;
    logic          run;
    logic          halt;
    logic [CW-1:0] cc;
    logic [CW-1:0] ic;
    string         name;
  } exp_t;

  exp_t exp_q[$];
  int   tb_cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  task automatic chk(input string name, input string field, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s.%s: got %0h expected %0h", name, field, act, expv);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= tb_cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.cyc < tb_cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s.missed: got cycle %0d expected cycle %0d", e.name, tb_cyc, e.cyc);
      end else begin
        chk(e.name, "pc",          pc,          e.pc);
        chk(e.name, "stat",        {61'd0, stat}, {61'd0, e.stat});
        chk(e.name, "running",     {63'd0, running}, {63'd0, e.run});
        chk(e.name, "halted",      {63'd0, halted},  {63'd0, e.halt});
        chk(e.name, "cycle_count", {60'd0, cycle_count}, {60'd0, e.cc});
        chk(e.name, "instr_count", {60'd0, instr_count}, {60'd0, e.ic});
        $display("txn %-10s cyc=%0d pc=%0h stat=%0d run=%0b halt=%0b cc=%0d ic=%0d",
                 e.name, tb_cyc, pc, stat, running, halted, cycle_count, instr_count);
      end
    end
  end

  // Drive one cycle of inputs and queue the state expected right after the next edge.
  task automatic drv(input string name, input logic rn, input logic st, input logic [63:0] pcu,
                     input logic [3:0] ic_in, input logic iv, input logic ie,
                     input logic [63:0] e_pc, input logic [2:0] e_stat, input logic e_run,
                     input logic e_halt, input int e_cc, input int e_ic);
    exp_t e;
    rst_n       = rn;
    start       = st;
    pc_updated  = pcu;
    icode       = ic_in;
    instr_valid = iv;
    imem_error  = ie;
    e.cyc  = tb_cyc + 1;
    e.pc   = e_pc;
    e.stat = e_stat;
    e.run  = e_run;
    e.halt = e_halt;
    e.cc   = e_cc[CW-1:0];
    e.ic   = e_ic[CW-1:0];
    e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pc_updated = '0; icode = '0; instr_valid = 1'b0; imem_error = 1'b0;

    // Reset with noisy inputs
    drv("reset0", 0, 1, 64'hFF, 4'h6, 1, 0, 64'h0, 3'd1, 0, 0, 0, 0);
    drv("reset1", 0, 1, 64'hFF, 4'h6, 1, 0, 64'h0, 3'd1, 0, 0, 0, 0);
    // Idle ignores fetch inputs, even a halt icode with imem_error
    drv("idle",   1, 0, 64'h55, 4'h0, 0, 1, 64'h0, 3'd1, 0, 0, 0, 0);
    drv("start",  1, 1, 64'h55, 4'h0, 0, 1, 64'h0, 3'd1, 1, 0, 0, 0);
    drv("run1",   1, 0, 64'h0A, 4'h6, 1, 0, 64'h0A, 3'd1, 1, 0, 1, 1);
    drv("run2",   1, 1, 64'h14, 4'h6, 1, 0, 64'h14, 3'd1, 1, 0, 2, 2);
    drv("run3",   1, 0, 64'h1E, 4'h6, 1, 0, 64'h1E, 3'd1, 1, 0, 3, 3);
    // Halt instruction, then sticky HALT
    drv("halt",   1, 0, 64'h1F, 4'h0, 1, 0, 64'h1E, 3'd2, 0, 1, 4, 3);
    drv("hstick1",1, 1, 64'h99, 4'h6, 1, 0, 64'h1E, 3'd2, 0, 1, 4, 3);
    drv("hstick2",1, 0, 64'h77, 4'h6, 0, 1, 64'h1E, 3'd2, 0, 1, 4, 3);

    // Fault priority: imem_error beats invalid and halt
    drv("rst_h",  0, 0, 64'h0,  4'h0, 0, 0, 64'h0, 3'd1, 0, 0, 0, 0);
    drv("startA", 1, 1, 64'h0,  4'h0, 1, 0, 64'h0, 3'd1, 1, 0, 0, 0);
    drv("retA",   1, 0, 64'h08, 4'h3, 1, 0, 64'h08, 3'd1, 1, 0, 1, 1);
    drv("adr",    1, 0, 64'h40, 4'h0, 0, 1, 64'h08, 3'd3, 0, 1, 2, 1);
    drv("adrhold",1, 1, 64'h48, 4'h6, 1, 0, 64'h08, 3'd3, 0, 1, 2, 1);

    drv("rst_b",  0, 0, 64'h0,  4'h0, 0, 0, 64'h0, 3'd1, 0, 0, 0, 0);
    drv("startB", 1, 1, 64'h0,  4'h0, 1, 0, 64'h0, 3'd1, 1, 0, 0, 0);
    drv("retB",   1, 0, 64'h10, 4'h6, 1, 0, 64'h10, 3'd1, 1, 0, 1, 1);
    drv("ins",    1, 0, 64'h50, 4'h6, 0, 0, 64'h10, 3'd4, 0, 1, 2, 1);

    // Reset mid-RUN after 5 instructions, then fresh start
    drv("rst_c",  0, 0, 64'h0,  4'h0, 0, 0, 64'h0, 3'd1, 0, 0, 0, 0);
    drv("startC", 1, 1, 64'h0,  4'h0, 1, 0, 64'h0, 3'd1, 1, 0, 0, 0);
    drv("c1",     1, 0, 64'h02, 4'h1, 1, 0, 64'h02, 3'd1, 1, 0, 1, 1);
    drv("c2",     1, 0, 64'h04, 4'h1, 1, 0, 64'h04, 3'd1, 1, 0, 2, 2);
    drv("c3",     1, 0, 64'h06, 4'h1, 1, 0, 64'h06, 3'd1, 1, 0, 3, 3);
    drv("c4",     1, 0, 64'h08, 4'h1, 1, 0, 64'h08, 3'd1, 1, 0, 4, 4);
    drv("c5",     1, 0, 64'h0A, 4'h1, 1, 0, 64'h0A, 3'd1, 1, 0, 5, 5);
    drv("rst_mid",0, 1, 64'hEE, 4'h1, 1, 0, 64'h0,  3'd1, 0, 0, 0, 0);
    drv("restart",1, 1, 64'h0,  4'h1, 1, 0, 64'h0,  3'd1, 1, 0, 0, 0);
    drv("c_new",  1, 0, 64'h30, 4'h2, 1, 0, 64'h30, 3'd1, 1, 0, 1, 1);

    // Counter wrap: 17 retirements in a 4-bit counter
    drv("rst_w",  0, 0, 64'h0,  4'h0, 0, 0, 64'h0, 3'd1, 0, 0, 0, 0);
    drv("startW", 1, 1, 64'h0,  4'h0, 1, 0, 64'h0, 3'd1, 1, 0, 0, 0);
    for (int k = 1; k <= 17; k++) begin
      drv($sformatf("w%0d", k), 1, 0, 64'(4 * k), 4'h6, 1, 0, 64'(4 * k), 3'd1, 1, 0, k % 16, k % 16);
    end
    drv("w_halt", 1, 0, 64'h99, 4'h0, 1, 0, 64'h44, 3'd2, 0, 1, 2, 1);
    drv("w_hold", 1, 1, 64'h98, 4'h6, 1, 0, 64'h44, 3'd2, 0, 1, 2, 1);

    repeat (3) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
